// File: rtl/ifetch_pkg.sv
// ============================================================================
// Module  : ifetch_pkg
// Brief   : Shared types and constants for the instruction prefetch unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ifetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   localparam logic [31:0] c_reset_pc   = 32'h0000_0000;
   localparam logic [31:0] c_word_bytes = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/ifetch_fifo.sv
// ============================================================================
// Module  : ifetch_fifo
// Brief   : Synchronous prefetch FIFO of {instr, pc} entries; flush wins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  fetch_entry_t            push_data,
   input  logic                    pop,
   input  logic                    flush,
   output fetch_entry_t            head,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty
);

   localparam int c_ptr_w = $clog2(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_one = 1;
   localparam logic [c_ptr_w:0]   c_cnt_one = 1;

   fetch_entry_t        r_mem [DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_ptr_w:0]    r_count;
   logic                w_do_push;
   logic                w_do_pop;

   assign w_do_push = push && !flush;
   assign w_do_pop  = pop && !flush && (r_count != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (flush) begin
         // Keep the read pointer so the head output holds its last value.
         r_wr_ptr <= r_rd_ptr;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
            r_wr_ptr        <= r_wr_ptr + c_ptr_one;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + c_cnt_one;
            2'b01:   r_count <= r_count - c_cnt_one;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head  = r_mem[r_rd_ptr];
   assign count = r_count;
   assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/ifetch_prefetch_unit.sv
// ============================================================================
// Module  : ifetch_prefetch_unit
// Brief   : Single-outstanding instruction fetcher feeding decode via a FIFO.
//           Optional same-cycle bypass of the ack word: IFETCH_BYPASS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ifetch_prefetch_unit
   import ifetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = c_reset_pc
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc
);

   localparam int                 c_cnt_w = $clog2(DEPTH) + 1;
   localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

   fetch_state_t         r_state;
   logic [31:0]          r_fetch_pc;
   logic [31:0]          r_imem_addr;
   logic                 r_imem_req;

   fetch_entry_t         w_head;
   fetch_entry_t         w_push_data;
   logic [c_cnt_w-1:0]   w_count;
   logic [c_cnt_w-1:0]   w_count_resv;
   logic                 w_empty;
   logic                 w_ack_take;
   logic                 w_bypass;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_issue_idle;
   logic                 w_reissue;
   logic [31:0]          w_next_pc;

   assign w_ack_take  = imem_ack && (r_state == WAIT) && !redirect;
   assign w_next_pc   = r_fetch_pc + c_word_bytes;
   assign w_push_data = {imem_rdata, r_fetch_pc};

`ifdef IFETCH_BYPASS_EN
   assign w_bypass    = w_ack_take && w_empty && instr_ready;
   assign instr_valid = !w_empty || w_ack_take;
   assign instr       = (w_empty && w_ack_take) ? imem_rdata : w_head.instr;
   assign instr_pc    = (w_empty && w_ack_take) ? r_fetch_pc : w_head.pc;
`else
   assign w_bypass    = 1'b0;
   assign instr_valid = !w_empty;
   assign instr       = w_head.instr;
   assign instr_pc    = w_head.pc;
`endif

   assign w_push = w_ack_take && !w_bypass;
   assign w_pop  = instr_valid && instr_ready && !w_empty;

   // The outstanding request owns a FIFO slot, so count the word landing now.
   assign w_count_resv = w_count + {{(c_cnt_w-1){1'b0}}, w_push};
   assign w_issue_idle = (r_state == IDLE) && !redirect && (w_count < c_depth);
   assign w_reissue    = w_ack_take && (w_count_resv < c_depth);

   ifetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_push_data),
      .pop       (w_pop),
      .flush     (redirect),
      .head      (w_head),
      .count     (w_count),
      .empty     (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_fetch_pc  <= RESET_PC;
         r_imem_req  <= 1'b0;
         r_imem_addr <= RESET_PC;
      end else begin
         if (redirect) begin
            r_fetch_pc <= align_word(redirect_pc);
         end else if (w_ack_take) begin
            r_fetch_pc <= w_next_pc;
         end

         case (r_state)
            IDLE: begin
               if (w_issue_idle) begin
                  r_imem_req  <= 1'b1;
                  r_imem_addr <= r_fetch_pc;
                  r_state     <= WAIT;
               end
            end
            WAIT: begin
               if (imem_ack) begin
                  // Back-to-back: the next request goes out in the cycle after the ack.
                  if (w_reissue) begin
                     r_imem_addr <= w_next_pc;
                  end else begin
                     r_imem_req <= 1'b0;
                     r_state    <= IDLE;
                  end
               end else if (redirect) begin
                  r_state <= DROP;
               end
            end
            DROP: begin
               if (imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_imem_req <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

   assign imem_req  = r_imem_req;
   assign imem_addr = r_imem_addr;

endmodule

`default_nettype wire

// File: tb/tb_ifetch_prefetch_unit.sv
// ============================================================================
// Module  : tb_ifetch_prefetch_unit
// Brief   : Directed scoreboard bench for ifetch_prefetch_unit (default build).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifetch_prefetch_unit;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_pc;

   logic        mem_auto;
   logic        auto_ack;
   logic [31:0] auto_data;
   int          auto_cnt;
   logic        man_ack;
   logic [31:0] man_data;

   exp_t        exp_q[$];
   logic [31:0] exp_addr_q[$];

   int          n_checks;
   int          n_fail;
   int          n_consumed;
   int          n_issued;
   int          n_acks;
   logic        last_req;
   logic        last_ack;

   assign imem_ack   = mem_auto ? auto_ack  : man_ack;
   assign imem_rdata = mem_auto ? auto_data : man_data;

   ifetch_prefetch_unit #(
      .DEPTH    (4),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory model: answers one request, one cycle after it is first seen.
   always @(posedge clk) begin
      #1;
      if (rst || !mem_auto) begin
         auto_ack = 1'b0;
         auto_cnt = 0;
      end else if (auto_ack) begin
         auto_ack = 1'b0;
         auto_cnt = imem_req ? 1 : 0;
      end else if (imem_req) begin
         auto_cnt++;
         if (auto_cnt >= 2) begin
            auto_ack  = 1'b1;
            auto_data = imem_addr + 32'h100;
            auto_cnt  = 0;
         end
      end else begin
         auto_cnt = 0;
      end
   end

   // Monitor: request addresses and consumed instructions against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         last_req = 1'b0;
         last_ack = 1'b0;
      end else begin
         if (imem_req && (!last_req || last_ack)) begin
            n_issued++;
            if (exp_addr_q.size() > 0) check("imem_addr", imem_addr, exp_addr_q.pop_front());
         end
         if (imem_ack) n_acks++;
         if (instr_valid && instr_ready && !redirect) begin
            n_consumed++;
            n_checks++;
            assert (exp_q.size() != 0) else begin
               n_fail++;
               $error("FAIL scoreboard_underflow: observed pc %h instr %h, expected no entry", instr_pc, instr);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("instr", instr, e.instr);
               check("instr_pc", instr_pc, e.pc);
            end
         end
         last_req = imem_req;
         last_ack = imem_ack;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] pc);
      exp_t e;
      e.pc    = pc;
      e.instr = pc + 32'h100;
      exp_q.push_back(e);
   endtask

   task automatic wait_consumed(input int k);
      int target;
      int i;
      target = n_consumed + k;
      i      = 0;
      while (n_consumed < target && i < 200) begin
         step(1);
         i++;
      end
      check("consumed", 32'(n_consumed), 32'(target));
   endtask

   task automatic wait_req();
      int i;
      i = 0;
      while (!imem_req && i < 50) begin
         step(1);
         i++;
      end
      check("wait_req", 32'(imem_req), 32'd1);
   endtask

   task automatic man_serve(input logic [31:0] data);
      wait_req();
      step(1);
      man_ack  = 1'b1;
      man_data = data;
      step(1);
      man_ack  = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      exp_q.delete();
      exp_addr_q.delete();
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      n_consumed  = 0;
      n_issued    = 0;
      n_acks      = 0;
      last_req    = 1'b0;
      last_ack    = 1'b0;
      mem_auto    = 1'b1;
      auto_ack    = 1'b0;
      auto_data   = 32'h0;
      auto_cnt    = 0;
      man_ack     = 1'b0;
      man_data    = 32'h0;
      instr_ready = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;

      // Reset state and basic sequential fetch
      do_reset();
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, 32'h0);
      exp_addr_q = '{32'h0, 32'h4, 32'h8};
      push_exp(32'h0);
      push_exp(32'h4);
      push_exp(32'h8);
      rst         = 1'b0;
      instr_ready = 1'b1;
      wait_consumed(3);
      instr_ready = 1'b0;

      // Backpressure: exactly DEPTH fetches, then the request line stays low
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC};
      rst      = 1'b0;
      n_acks   = 0;
      n_issued = 0;
      step(20);
      check("full_acks", 32'(n_acks), 32'd4);
      check("full_issued", 32'(n_issued), 32'd4);
      check("full_req", 32'(imem_req), 32'd0);
      check("full_valid", 32'(instr_valid), 32'd1);
      check("full_head_pc", instr_pc, 32'h0);
      check("full_head_instr", instr, 32'h100);
      for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
      instr_ready = 1'b1;
      wait_consumed(6);
      instr_ready = 1'b0;

      // Redirect while waiting; the late 0xDEAD word must be dropped
      mem_auto = 1'b0;
      do_reset();
      exp_addr_q = '{32'h0, 32'h1C};
      rst = 1'b0;
      wait_req();
      redirect    = 1'b1;
      redirect_pc = 32'h1C;
      step(1);
      redirect = 1'b0;
      check("drop_req", 32'(imem_req), 32'd1);
      check("drop_addr_stable", imem_addr, 32'h0);
      check("drop_valid", 32'(instr_valid), 32'd0);
      step(1);
      man_ack  = 1'b1;
      man_data = 32'h0000_DEAD;
      step(1);
      man_ack  = 1'b0;
      mem_auto = 1'b1;
      push_exp(32'h1C);
      push_exp(32'h20);
      instr_ready = 1'b1;
      wait_consumed(2);
      instr_ready = 1'b0;

      // Redirect coincident with ack and pop while two entries are buffered
      mem_auto = 1'b0;
      do_reset();
      exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h10};
      rst = 1'b0;
      man_serve(32'h100);
      man_serve(32'h104);
      wait_req();
      step(1);
      check("two_valid", 32'(instr_valid), 32'd1);
      check("two_head_pc", instr_pc, 32'h0);
      man_ack     = 1'b1;
      man_data    = 32'h108;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0013;
      instr_ready = 1'b1;
      push_exp(32'h10);
      push_exp(32'h14);
      step(1);
      man_ack  = 1'b0;
      redirect = 1'b0;
      mem_auto = 1'b1;
      check("flush_valid", 32'(instr_valid), 32'd0);
      wait_consumed(2);
      instr_ready = 1'b0;
      step(20);
      check("refill_req", 32'(imem_req), 32'd0);
      check("refill_valid", 32'(instr_valid), 32'd1);

      // Fetch address wraps from the top of the address space
      exp_q.delete();
      exp_addr_q  = '{32'hFFFF_FFFC, 32'h0};
      push_exp(32'hFFFF_FFFC);
      push_exp(32'h0);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step(1);
      redirect    = 1'b0;
      instr_ready = 1'b1;
      wait_consumed(2);
      instr_ready = 1'b0;
      step(20);

      // Reset in the middle of a request; a late ack must be ignored
      mem_auto = 1'b0;
      exp_q.delete();
      exp_addr_q  = '{32'h40};
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      step(1);
      redirect = 1'b0;
      wait_req();
      rst = 1'b1;
      #1;
      check("async_rst_req", 32'(imem_req), 32'd0);
      check("async_rst_valid", 32'(instr_valid), 32'd0);
      check("async_rst_instr", instr, 32'h0);
      check("async_rst_instr_pc", instr_pc, 32'h0);
      step(2);
      exp_q.delete();
      exp_addr_q = '{32'h0};
      push_exp(32'h0);
      rst      = 1'b0;
      man_ack  = 1'b1;
      man_data = 32'h0000_0BAD;
      step(1);
      man_ack     = 1'b0;
      mem_auto    = 1'b1;
      instr_ready = 1'b1;
      wait_consumed(1);
      instr_ready = 1'b0;
      step(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
